// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, buffer-state and width constants for the ALU result selector
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_0   = 3'd0;
   localparam logic [2:0] OP_1   = 3'd1;
   localparam logic [2:0] OP_2   = 3'd2;
   localparam logic [2:0] OP_3   = 3'd3;
   localparam logic [2:0] OP_4   = 3'd4;
   localparam logic [2:0] OP_5   = 3'd5;
   localparam logic [2:0] OP_6   = 3'd6;
   localparam logic [2:0] OP_7   = 3'd7;
   localparam logic [2:0] OP_AND = OP_3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/alu_result_mux_if.sv
// rtl/alu_result_mux_if.sv - function-unit inputs plus upstream/downstream valid/ready bundle
interface alu_result_mux_if #(
   parameter int WIDTH = alu_pkg::ALU_WIDTH
);
   logic [WIDTH-1:0] bigMuxIn0;
   logic [WIDTH-1:0] bigMuxIn1;
   logic [WIDTH-1:0] bigMuxIn2;
   logic [WIDTH-1:0] bigMuxIn3;
   logic [WIDTH-1:0] bigMuxIn4;
   logic [WIDTH-1:0] bigMuxIn5;
   logic [WIDTH-1:0] bigMuxIn6;
   logic [WIDTH-1:0] bigMuxIn7;
   logic [2:0]       opSel;
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] aluOut;
   logic [2:0]       opOut;
   logic             zeroFlag;
   logic             parityFlag;
   logic             outValid;
   logic             outReady;

   modport master (
      output bigMuxIn0, bigMuxIn1, bigMuxIn2, bigMuxIn3,
      output bigMuxIn4, bigMuxIn5, bigMuxIn6, bigMuxIn7,
      output opSel, inValid, outReady,
      input  inReady, aluOut, opOut, zeroFlag, parityFlag, outValid
   );

   modport slave (
      input  bigMuxIn0, bigMuxIn1, bigMuxIn2, bigMuxIn3,
      input  bigMuxIn4, bigMuxIn5, bigMuxIn6, bigMuxIn7,
      input  opSel, inValid, outReady,
      output inReady, aluOut, opOut, zeroFlag, parityFlag, outValid
   );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - 2-entry FIFO with EMPTY/ONE/FULL occupancy FSM
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int PW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [PW-1:0] push_data,
   output logic          pop_valid,
   input  logic          pop_ready,
   output logic [PW-1:0] pop_data
);
   buf_state_t    state_q, state_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic          push, pop;

   // Ready/valid decode from registered state only, so outReady never reaches inReady.
   assign push_ready = (state_q != ST_FULL);
   assign pop_valid  = (state_q != ST_EMPTY);
   assign pop_data   = head_q;
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         ST_EMPTY: begin
            if (push) begin
               head_d  = push_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (push && pop) begin
               head_d = push_data;
            end else if (push) begin
               tail_d  = push_data;
               state_d = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end
endmodule

// File: rtl/alu_result_mux.sv
// rtl/alu_result_mux.sv - 8:1 function-unit select with zero flag into a 2-entry output buffer
// Optional ALU_PARITY_EN adds a per-entry parity flag; otherwise parityFlag is tied to 0.
module alu_result_mux
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic           clk,
   input  logic           reset,
   alu_result_mux_if.slave bus
);
`ifdef ALU_PARITY_EN
   localparam int FLAG_W = 2;
`else
   localparam int FLAG_W = 1;
`endif
   localparam int PW = WIDTH + 3 + FLAG_W;

   logic [WIDTH-1:0] sel_result;
   logic             sel_zero;
   logic [PW-1:0]    push_data;
   logic [PW-1:0]    head_data;

   always_comb begin
      sel_result = '0;
      case (bus.opSel)
         OP_0:    sel_result = bus.bigMuxIn0;
         OP_1:    sel_result = bus.bigMuxIn1;
         OP_2:    sel_result = bus.bigMuxIn2;
         OP_AND:  sel_result = bus.bigMuxIn3;
         OP_4:    sel_result = bus.bigMuxIn4;
         OP_5:    sel_result = bus.bigMuxIn5;
         OP_6:    sel_result = bus.bigMuxIn6;
         OP_7:    sel_result = bus.bigMuxIn7;
         default: sel_result = '0;
      endcase
   end

   assign sel_zero = (sel_result == '0);

   // Flags are frozen into the entry at accept time, not recomputed at the head.
`ifdef ALU_PARITY_EN
   assign push_data      = {bus.opSel, ^sel_result, sel_zero, sel_result};
   assign bus.parityFlag = head_data[WIDTH+1];
`else
   assign push_data      = {bus.opSel, sel_zero, sel_result};
   assign bus.parityFlag = 1'b0;
`endif

   assign bus.aluOut   = head_data[WIDTH-1:0];
   assign bus.zeroFlag = head_data[WIDTH];
   assign bus.opOut    = head_data[PW-1 -: 3];

   alu_result_fifo #(.PW(PW)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus.inValid),
      .push_ready (bus.inReady),
      .push_data  (push_data),
      .pop_valid  (bus.outValid),
      .pop_ready  (bus.outReady),
      .pop_data   (head_data)
   );
endmodule

// File: tb/tb_alu_result_mux.sv
// tb/tb_alu_result_mux.sv - directed bench with per-cycle queue model for alu_result_mux
module tb_alu_result_mux;
   import alu_pkg::*;
   localparam int W = ALU_WIDTH;

   typedef struct {
      logic [W-1:0] data;
      logic [2:0]   op;
      logic         zero;
      logic         par;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   ent_t         mq[$];
   ent_t         last;
   ent_t         h;
   ent_t         newe;
   logic         m_push, m_pop;
   logic [W-1:0] out_log[$];
   logic [W-1:0] v;

   always #5 clk = ~clk;

   alu_result_mux_if #(.WIDTH(W)) bus ();
   alu_result_mux #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] in_of(input logic [2:0] op);
      case (op)
         3'd0: return bus.bigMuxIn0;
         3'd1: return bus.bigMuxIn1;
         3'd2: return bus.bigMuxIn2;
         3'd3: return bus.bigMuxIn3;
         3'd4: return bus.bigMuxIn4;
         3'd5: return bus.bigMuxIn5;
         3'd6: return bus.bigMuxIn6;
         default: return bus.bigMuxIn7;
      endcase
   endfunction

   function automatic logic exp_par(input logic [W-1:0] d);
`ifdef ALU_PARITY_EN
      return ^d;
`else
      return 1'b0 & d[0];
`endif
   endfunction

   task automatic set_in(input logic [2:0] op, input logic [W-1:0] d);
      case (op)
         3'd0: bus.bigMuxIn0 = d;
         3'd1: bus.bigMuxIn1 = d;
         3'd2: bus.bigMuxIn2 = d;
         3'd3: bus.bigMuxIn3 = d;
         3'd4: bus.bigMuxIn4 = d;
         3'd5: bus.bigMuxIn5 = d;
         3'd6: bus.bigMuxIn6 = d;
         default: bus.bigMuxIn7 = d;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] d);
      logic ok;
      ok = 1'b0;
      set_in(op, d);
      bus.opSel   = op;
      bus.inValid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.inReady) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_accept_timeout", {31'd0, ok}, 32'd1);
      step();
      bus.inValid = 1'b0;
   endtask

   // Model: a bounded queue of accepted entries; head shown when non-empty, else last shown.
   always @(negedge clk) begin
      if (reset) begin
         mq.delete();
         last = '{data: '0, op: '0, zero: 1'b0, par: 1'b0};
         chk("rst_outValid", {31'd0, bus.outValid}, 32'd0);
         chk("rst_inReady", {31'd0, bus.inReady}, 32'd1);
         chk("rst_aluOut", {24'd0, bus.aluOut}, 32'd0);
      end else begin
         h = (mq.size() != 0) ? mq[0] : last;
         chk("m_outValid", {31'd0, bus.outValid}, {31'd0, mq.size() != 0});
         chk("m_inReady", {31'd0, bus.inReady}, {31'd0, mq.size() < 2});
         chk("m_aluOut", {24'd0, bus.aluOut}, {24'd0, h.data});
         chk("m_opOut", {29'd0, bus.opOut}, {29'd0, h.op});
         chk("m_zeroFlag", {31'd0, bus.zeroFlag}, {31'd0, h.zero});
         chk("m_parityFlag", {31'd0, bus.parityFlag}, {31'd0, h.par});
         if (bus.outValid && bus.outReady) out_log.push_back(bus.aluOut);
         if (mq.size() != 0) last = mq[0];
         m_pop  = bus.outReady && (mq.size() > 0);
         m_push = bus.inValid && (mq.size() < 2);
         newe.data = in_of(bus.opSel);
         newe.op   = bus.opSel;
         newe.zero = (newe.data == '0);
         newe.par  = exp_par(newe.data);
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back(newe);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.bigMuxIn0 = '0; bus.bigMuxIn1 = '0; bus.bigMuxIn2 = '0; bus.bigMuxIn3 = '0;
      bus.bigMuxIn4 = '0; bus.bigMuxIn5 = '0; bus.bigMuxIn6 = '0; bus.bigMuxIn7 = '0;
      bus.opSel = '0; bus.inValid = 1'b0; bus.outReady = 1'b0;

      repeat (2) @(negedge clk);
      chk("reset_aluOut", {24'd0, bus.aluOut}, 32'd0);
      chk("reset_opOut", {29'd0, bus.opOut}, 32'd0);
      chk("reset_zeroFlag", {31'd0, bus.zeroFlag}, 32'd0);
      chk("reset_parityFlag", {31'd0, bus.parityFlag}, 32'd0);
      chk("reset_outValid", {31'd0, bus.outValid}, 32'd0);
      chk("reset_inReady", {31'd0, bus.inReady}, 32'd1);
      step();
      reset = 1'b0;
      step();

      // Select the AND unit.
      bus.bigMuxIn0 = 8'hA0; bus.bigMuxIn1 = 8'hB1; bus.bigMuxIn2 = 8'hC2; bus.bigMuxIn3 = 8'h0F;
      bus.bigMuxIn4 = 8'h44; bus.bigMuxIn5 = 8'h55; bus.bigMuxIn6 = 8'h66; bus.bigMuxIn7 = 8'h77;
      bus.opSel = 3'd3; bus.inValid = 1'b1; bus.outReady = 1'b1;
      step();
      bus.inValid = 1'b0;
      @(negedge clk);
      chk("sel_aluOut", {24'd0, bus.aluOut}, 32'h0F);
      chk("sel_opOut", {29'd0, bus.opOut}, 32'd3);
      chk("sel_zeroFlag", {31'd0, bus.zeroFlag}, 32'd0);
      chk("sel_outValid", {31'd0, bus.outValid}, 32'd1);
      step();
      step();

      // Zero then parity.
      set_in(3'd0, 8'h00); bus.opSel = 3'd0; bus.inValid = 1'b1;
      step();
      set_in(3'd1, 8'h07); bus.opSel = 3'd1;
      @(negedge clk);
      chk("zp0_zeroFlag", {31'd0, bus.zeroFlag}, 32'd1);
      chk("zp0_parityFlag", {31'd0, bus.parityFlag}, 32'd0);
      step();
      bus.inValid = 1'b0;
      @(negedge clk);
      chk("zp7_aluOut", {24'd0, bus.aluOut}, 32'h07);
      chk("zp7_zeroFlag", {31'd0, bus.zeroFlag}, 32'd0);
`ifdef ALU_PARITY_EN
      chk("zp7_parityFlag", {31'd0, bus.parityFlag}, 32'd1);
`else
      chk("zp7_parityFlag", {31'd0, bus.parityFlag}, 32'd0);
`endif
      step();
      step();

      // Backpressure with hold while FULL.
      out_log.delete();
      bus.outReady = 1'b0;
      send(3'd0, 8'h11);
      send(3'd0, 8'h22);
      set_in(3'd0, 8'h33); bus.opSel = 3'd0; bus.inValid = 1'b1;
      @(negedge clk);
      chk("bp_inReady_full", {31'd0, bus.inReady}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         bus.bigMuxIn0 = W'($urandom); bus.bigMuxIn1 = W'($urandom);
         bus.bigMuxIn2 = W'($urandom); bus.bigMuxIn3 = W'($urandom);
         bus.bigMuxIn4 = W'($urandom); bus.bigMuxIn5 = W'($urandom);
         bus.bigMuxIn6 = W'($urandom); bus.bigMuxIn7 = W'($urandom);
         bus.opSel = 3'($urandom); bus.inValid = 1'($urandom);
         @(negedge clk);
         chk("hold_aluOut", {24'd0, bus.aluOut}, 32'h11);
         chk("hold_opOut", {29'd0, bus.opOut}, 32'd0);
         chk("hold_zeroFlag", {31'd0, bus.zeroFlag}, 32'd0);
         chk("hold_outValid", {31'd0, bus.outValid}, 32'd1);
      end
      step();
      bus.outReady = 1'b1;
      send(3'd0, 8'h33);
      repeat (3) step();
      chk("bp_count", out_log.size(), 32'd3);
      if (out_log.size() == 3) begin
         chk("bp_first", {24'd0, out_log[0]}, 32'h11);
         chk("bp_second", {24'd0, out_log[1]}, 32'h22);
         chk("bp_third", {24'd0, out_log[2]}, 32'h33);
      end

      // Simultaneous push and pop in ONE, values 1..10.
      out_log.delete();
      set_in(3'd0, 8'd1); bus.opSel = 3'd0; bus.inValid = 1'b1;
      for (int i = 2; i <= 11; i++) begin
         @(negedge clk);
         chk("sim_inReady", {31'd0, bus.inReady}, 32'd1);
         if (i > 2) chk("sim_outValid", {31'd0, bus.outValid}, 32'd1);
         step();
         if (i <= 10) set_in(3'd0, W'(i));
         else bus.inValid = 1'b0;
      end
      repeat (3) step();
      chk("sim_count", out_log.size(), 32'd10);
      for (int i = 0; i < 10 && i < out_log.size(); i++) begin
         v = out_log[i];
         chk("sim_order", {24'd0, v}, i + 1);
      end

      // Reset while FULL.
      bus.outReady = 1'b0;
      send(3'd1, 8'h5A);
      send(3'd2, 8'hA5);
      @(negedge clk);
      chk("pre_rst_inReady", {31'd0, bus.inReady}, 32'd0);
      step();
      reset = 1'b1;
      #1;
      chk("midrst_outValid", {31'd0, bus.outValid}, 32'd0);
      chk("midrst_inReady", {31'd0, bus.inReady}, 32'd1);
      chk("midrst_aluOut", {24'd0, bus.aluOut}, 32'd0);
      step();
      reset = 1'b0;
      bus.outReady = 1'b1;
      send(3'd5, 8'h3C);
      @(negedge clk);
      chk("postrst_aluOut", {24'd0, bus.aluOut}, 32'h3C);
      chk("postrst_opOut", {29'd0, bus.opOut}, 32'd5);
      chk("postrst_outValid", {31'd0, bus.outValid}, 32'd1);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
